// File: rtl/frame_defs.sv
`default_nettype none
// ============================================================================
//  frame_defs
//  Shared Ethernet constants, station addresses and receiver state encodings.
//  Revision: 1.0
// ============================================================================
package frame_defs;

    localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;

    localparam logic [47:0] NF2C0_ADDR = 48'h004e46324300;
    localparam logic [47:0] NF2C1_ADDR = 48'h004e46324301;
    localparam logic [47:0] BCAST_ADDR = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_MAC_DST     = 3'd1,
        S_MAC_SRC     = 3'd2,
        S_ETH_TYPE    = 3'd3,
        S_PAYLOAD     = 3'd4,
        S_WAIT_STATUS = 3'd5,
        S_DROP        = 3'd6
    } rx_state_t;

    function automatic logic [13:0] sat_inc14(input logic [13:0] v);
        return (v == 14'h3FFF) ? v : v + 14'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter16.sv
`default_nettype none
// ============================================================================
//  sat_counter16
//  16-bit increment-enable counter that sticks at all-ones.
//  Revision: 1.0
// ============================================================================
module sat_counter16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc,
    output logic [15:0] o_count
);

    logic [15:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 16'd0;
        end else if (i_inc && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/frame_receiver.sv
`default_nettype none
// ============================================================================
//  frame_receiver
//  Parses MAC receive bytes, filters on address/EtherType, counts outcomes.
//  Revision: 1.0
// ============================================================================
module frame_receiver
    import frame_defs::*;
#(
    parameter logic [47:0] MY_ADDR      = NF2C0_ADDR,
    parameter bit          ACCEPT_BCAST = 1'b1,
    parameter logic [15:0] EXPECT_TYPE  = ETH_TYPE_ARP,
    parameter int          MAX_LEN      = 1518,
    parameter int          STATUS_TMO   = 16
) (
    input  logic        rx_clk,
    input  logic        reset,
    output logic        conf_rx_en,
    output logic        conf_rx_jumbo_en,
    output logic        conf_rx_no_chk_crc,
    input  logic [7:0]  mac_rx_data,
    input  logic        mac_rx_dvld,
    input  logic        mac_rx_goodframe,
    input  logic        mac_rx_badframe,
    output logic        frame_match,
    output logic [47:0] rx_src_addr,
    output logic [15:0] rx_eth_type,
    output logic [13:0] rx_len,
    output logic [15:0] good_count,
    output logic [15:0] bad_count
);

    rx_state_t   r_state, w_state;
    logic [13:0] r_cnt, w_cnt;
    logic [47:0] r_dst, w_dst;
    logic [47:0] r_src, w_src;
    logic [15:0] r_type, w_type;
    logic        r_reject, w_reject;
    logic [15:0] r_tmr, w_tmr;
    logic        r_armed;
    logic        r_conf_en;
    logic        r_match, w_match;
    logic        w_latch;
    logic        w_good_inc, w_bad_inc;
    logic [47:0] r_src_lat;
    logic [15:0] r_type_lat;
    logic [13:0] r_len_lat;

    logic [13:0] w_cnt_inc;
    logic        w_over;
    logic [47:0] w_dst_shift;
    logic        w_dst_hit;
    logic        w_tmo;
    logic        w_good_only;
    logic        w_any_strobe;

    assign w_cnt_inc    = sat_inc14(r_cnt);
    assign w_over       = int'(w_cnt_inc) > MAX_LEN;
    assign w_dst_shift  = {r_dst[39:0], mac_rx_data};
    assign w_dst_hit    = (w_dst_shift == MY_ADDR) ||
                          (ACCEPT_BCAST && (w_dst_shift == BCAST_ADDR));
    assign w_tmo        = int'(r_tmr) >= (STATUS_TMO - 1);
    assign w_good_only  = mac_rx_goodframe && !mac_rx_badframe;
    assign w_any_strobe = mac_rx_goodframe || mac_rx_badframe;

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_dst      = r_dst;
        w_src      = r_src;
        w_type     = r_type;
        w_reject   = r_reject;
        w_tmr      = r_tmr;
        w_match    = 1'b0;
        w_latch    = 1'b0;
        w_good_inc = 1'b0;
        w_bad_inc  = 1'b0;

        case (r_state)
            S_IDLE: begin
                // r_armed blocks a frame already in flight when reset released
                if (mac_rx_dvld && r_armed) begin
                    w_dst    = {40'd0, mac_rx_data};
                    w_cnt    = 14'd1;
                    w_reject = 1'b0;
                    w_state  = S_MAC_DST;
                end
            end

            S_MAC_DST, S_MAC_SRC, S_ETH_TYPE: begin
                if (mac_rx_dvld) begin
                    w_cnt = w_cnt_inc;
                    if (r_state == S_MAC_DST)      w_dst  = w_dst_shift;
                    else if (r_state == S_MAC_SRC) w_src  = {r_src[39:0], mac_rx_data};
                    else                           w_type = {r_type[7:0], mac_rx_data};

                    if (w_over) begin
                        w_tmr   = 16'd0;
                        w_state = S_DROP;
                    end else if ((r_state == S_MAC_DST) && (r_cnt == 14'd5)) begin
                        w_tmr   = 16'd0;
                        w_state = w_dst_hit ? S_MAC_SRC : S_DROP;
                    end else if ((r_state == S_MAC_SRC) && (r_cnt == 14'd11)) begin
                        w_state = S_ETH_TYPE;
                    end else if ((r_state == S_ETH_TYPE) && (r_cnt == 14'd13)) begin
                        w_state = S_PAYLOAD;
                    end
                end else begin
                    w_reject = 1'b1;
                    w_tmr    = 16'd0;
                    w_state  = S_WAIT_STATUS;
                end
            end

            S_PAYLOAD: begin
                if (mac_rx_dvld) begin
                    w_cnt = w_cnt_inc;
                    if (w_over) begin
                        w_tmr   = 16'd0;
                        w_state = S_DROP;
                    end
                end else begin
                    w_tmr   = 16'd0;
                    w_state = S_WAIT_STATUS;
                end
            end

            S_WAIT_STATUS: begin
                if (mac_rx_dvld) begin
                    w_bad_inc = 1'b1;
                    w_dst     = {40'd0, mac_rx_data};
                    w_cnt     = 14'd1;
                    w_reject  = 1'b0;
                    w_state   = S_MAC_DST;
                end else if (w_good_only && !r_reject && (r_type == EXPECT_TYPE)) begin
                    w_match    = 1'b1;
                    w_latch    = 1'b1;
                    w_good_inc = 1'b1;
                    w_state    = S_IDLE;
                end else if (w_any_strobe || w_tmo) begin
                    w_bad_inc = 1'b1;
                    w_state   = S_IDLE;
                end else begin
                    w_tmr = r_tmr + 16'd1;
                end
            end

            S_DROP: begin
                if (mac_rx_dvld) begin
                    w_cnt = w_cnt_inc;
                    w_tmr = 16'd0;
                end else if (w_any_strobe || w_tmo) begin
                    w_bad_inc = 1'b1;
                    w_state   = S_IDLE;
                end else begin
                    w_tmr = r_tmr + 16'd1;
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 14'd0;
            r_dst      <= 48'd0;
            r_src      <= 48'd0;
            r_type     <= 16'd0;
            r_reject   <= 1'b0;
            r_tmr      <= 16'd0;
            r_armed    <= 1'b0;
            r_conf_en  <= 1'b0;
            r_match    <= 1'b0;
            r_src_lat  <= 48'd0;
            r_type_lat <= 16'd0;
            r_len_lat  <= 14'd0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_dst     <= w_dst;
            r_src     <= w_src;
            r_type    <= w_type;
            r_reject  <= w_reject;
            r_tmr     <= w_tmr;
            r_conf_en <= 1'b1;
            r_match   <= w_match;
            if (!mac_rx_dvld) begin
                r_armed <= 1'b1;
            end
            if (w_latch) begin
                r_src_lat  <= r_src;
                r_type_lat <= r_type;
                r_len_lat  <= r_cnt;
            end
        end
    end

    sat_counter16 u_good_cnt (
        .clk     (rx_clk),
        .rst     (reset),
        .i_inc   (w_good_inc),
        .o_count (good_count)
    );

    sat_counter16 u_bad_cnt (
        .clk     (rx_clk),
        .rst     (reset),
        .i_inc   (w_bad_inc),
        .o_count (bad_count)
    );

    assign conf_rx_en         = r_conf_en;
    assign conf_rx_jumbo_en   = 1'b0;
    assign conf_rx_no_chk_crc = 1'b0;
    assign frame_match        = r_match;
    assign rx_src_addr        = r_src_lat;
    assign rx_eth_type        = r_type_lat;
    assign rx_len             = r_len_lat;

endmodule
`default_nettype wire

// File: tb/tb_frame_receiver.sv
`default_nettype none
// ============================================================================
//  tb_frame_receiver
//  Directed plus randomized frames against a frame-level reference model.
//  Revision: 1.0
// ============================================================================
module tb_frame_receiver;

    localparam logic [47:0] MY   = 48'h004e46324300;
    localparam logic [47:0] OTHR = 48'h004e46324301;
    localparam logic [47:0] BC   = 48'hFFFFFFFFFFFF;
    localparam logic [15:0] ARP  = 16'h0806;
    localparam logic [15:0] IP4  = 16'h0800;
    localparam int          MAXL = 1518;
    localparam int          TMO  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  data = 8'd0;
    logic        dvld = 1'b0;
    logic        good = 1'b0;
    logic        bad  = 1'b0;
    logic        conf_en, conf_jumbo, conf_nocrc, match;
    logic [47:0] src_addr;
    logic [15:0] eth_type, good_cnt, bad_cnt;
    logic [13:0] len_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          pulses  = 0;

    int          exp_pulses = 0;
    logic [15:0] exp_good = 16'd0;
    logic [15:0] exp_bad  = 16'd0;
    logic [47:0] exp_src  = 48'd0;
    logic [15:0] exp_type = 16'd0;
    logic [13:0] exp_len  = 14'd0;

    frame_receiver dut (
        .rx_clk             (clk),
        .reset              (rst),
        .conf_rx_en         (conf_en),
        .conf_rx_jumbo_en   (conf_jumbo),
        .conf_rx_no_chk_crc (conf_nocrc),
        .mac_rx_data        (data),
        .mac_rx_dvld        (dvld),
        .mac_rx_goodframe   (good),
        .mac_rx_badframe    (bad),
        .frame_match        (match),
        .rx_src_addr        (src_addr),
        .rx_eth_type        (eth_type),
        .rx_len             (len_o),
        .good_count         (good_cnt),
        .bad_count          (bad_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (match === 1'b1) pulses++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fbyte(input int i, input logic [47:0] dst,
                                         input logic [47:0] src, input logic [15:0] typ);
        if (i < 6)       return dst[47-8*i -: 8];
        else if (i < 12) return src[47-8*(i-6) -: 8];
        else if (i < 14) return typ[15-8*(i-12) -: 8];
        else             return 8'($urandom);
    endfunction

    task automatic drive_frame(input int len, input logic [47:0] dst,
                               input logic [15:0] typ, output logic [47:0] src);
        src = {16'($urandom), $urandom};
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            dvld = 1'b1;
            data = fbyte(i, dst, src, typ);
        end
        @(posedge clk); #1;
        dvld = 1'b0;
        data = 8'd0;
    endtask

    // kind: 0 none, 1 good, 2 bad, 3 both
    task automatic send_status(input int kind);
        @(posedge clk); #1;
        good = (kind == 1) || (kind == 3);
        bad  = (kind == 2) || (kind == 3);
        @(posedge clk); #1;
        good = 1'b0;
        bad  = 1'b0;
        repeat (3) @(posedge clk);
        if (kind == 0) repeat (TMO + 6) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model(input int len, input logic [47:0] dst, input logic [15:0] typ,
                         input logic [47:0] src, input int kind);
        if ((len >= 14) && (len <= MAXL) && ((dst == MY) || (dst == BC)) &&
            (typ == ARP) && (kind == 1)) begin
            exp_pulses++;
            if (exp_good != 16'hFFFF) exp_good++;
            exp_src  = src;
            exp_type = typ;
            exp_len  = 14'(len);
        end else begin
            if (exp_bad != 16'hFFFF) exp_bad++;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pulses"}, 64'(pulses), 64'(exp_pulses));
        chk({tag, ".good"},   64'(good_cnt), 64'(exp_good));
        chk({tag, ".bad"},    64'(bad_cnt),  64'(exp_bad));
        chk({tag, ".src"},    64'(src_addr), 64'(exp_src));
        chk({tag, ".type"},   64'(eth_type), 64'(exp_type));
        chk({tag, ".len"},    64'(len_o),    64'(exp_len));
    endtask

    task automatic frame(input string tag, input int len, input logic [47:0] dst,
                         input logic [15:0] typ, input int kind);
        logic [47:0] s;
        drive_frame(len, dst, typ, s);
        send_status(kind);
        model(len, dst, typ, s, kind);
        check_all(tag);
    endtask

    initial begin
        logic [47:0] s;
        logic [47:0] s2;
        logic [47:0] d;
        logic [15:0] t;
        int          ln;
        int          k;
        int          p0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.conf_en", 64'(conf_en), 64'd0);
        chk("rst.match",   64'(match),   64'd0);
        check_all("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("conf.en",    64'(conf_en),    64'd1);
        chk("conf.jumbo", 64'(conf_jumbo), 64'd0);
        chk("conf.nocrc", 64'(conf_nocrc), 64'd0);

        frame("arp60",   60, MY,  ARP, 1);
        chk("arp60.type_const", 64'(eth_type), 64'h0806);
        chk("arp60.len_const",  64'(len_o),    64'd60);
        frame("bcast_badfcs", 64, BC,   ARP, 2);
        frame("wrong_dst",    60, OTHR, ARP, 1);
        frame("wrong_type",   60, MY,   IP4, 1);
        frame("runt10",       10, MY,   ARP, 1);
        frame("oversize",   1600, MY,   ARP, 1);
        frame("both_strobe",  60, MY,   ARP, 3);
        frame("max_len",    MAXL, BC,   ARP, 1);
        frame("max_plus1", MAXL + 1, MY, ARP, 1);

        // timeout: nothing counted early, counted after the window
        drive_frame(60, MY, ARP, s);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("tmo.early_bad", 64'(bad_cnt), 64'(exp_bad));
        repeat (15) @(posedge clk);
        @(negedge clk);
        model(60, MY, ARP, s, 0);
        check_all("tmo");

        // new frame starting while the previous one awaits status
        drive_frame(60, MY, ARP, s);
        drive_frame(70, BC, ARP, s2);
        send_status(1);
        model(60, MY, ARP, s, 0);
        model(70, BC, ARP, s2, 1);
        check_all("back2back");

        for (int n = 0; n < 12; n++) begin
            ln = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 13))
                                             : int'($urandom_range(14, 90));
            k  = int'($urandom_range(0, 2));
            d  = (k == 0) ? MY : ((k == 1) ? BC : {16'($urandom), $urandom});
            t  = ($urandom_range(0, 1) == 1) ? ARP : IP4;
            k  = int'($urandom_range(0, 3));
            frame("rand", ln, d, t, k);
        end

        // reset in the middle of a frame, released while dvld still high
        p0 = pulses;
        s  = {16'($urandom), $urandom};
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            dvld = 1'b1;
            data = fbyte(i, MY, s, ARP);
        end
        #2 rst = 1'b1;
        @(negedge clk);
        chk("midrst.match", 64'(match),    64'd0);
        chk("midrst.good",  64'(good_cnt), 64'd0);
        chk("midrst.bad",   64'(bad_cnt),  64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 20; i < 60; i++) begin
            @(posedge clk); #1;
            dvld = 1'b1;
            data = fbyte(i, MY, s, ARP);
        end
        @(posedge clk); #1;
        dvld = 1'b0;
        send_status(1);
        exp_good   = 16'd0;
        exp_bad    = 16'd0;
        exp_src    = 48'd0;
        exp_type   = 16'd0;
        exp_len    = 14'd0;
        exp_pulses = p0;
        check_all("midrst");

        frame("after_rst", 60, MY, ARP, 1);

        // good counter at its ceiling
        force dut.u_good_cnt.r_count = 16'hFFFF;
        @(posedge clk); #1;
        release dut.u_good_cnt.r_count;
        exp_good = 16'hFFFF;
        @(negedge clk);
        chk("preload.good", 64'(good_cnt), 64'hFFFF);
        frame("sat_good", 60, MY, ARP, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
